// File: rtl/id_issue_queue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_issue_queue_pkg : payload type shared by the decode-to-issue queue    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package id_issue_queue_pkg;

  // Local stand-in carrying the subset of the scoreboard entry this block touches.
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  trans_id;
    logic [6:0]  fu_op;
  } scoreboard_entry_t;

endpackage
`default_nettype wire

// File: rtl/id_issue_ctrl_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_issue_ctrl_counter : up/down counter of buffered control-flow entries |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module id_issue_ctrl_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/id_issue_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_issue_queue : circular buffer between decode and issue with a cap on  |
// |                  in-flight control-flow entries                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module id_issue_queue
  import id_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_CF  = 1,
  parameter type         entry_t = scoreboard_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  entry_t                     decoded_i,
  input  logic                       decoded_is_cf_i,
  input  logic                       decoded_valid_i,
  output logic                       decoded_ready_o,
  output entry_t                     issue_entry_o,
  output logic                       issue_is_cf_o,
  output logic                       issue_valid_o,
  input  logic                       issue_ack_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(MAX_CF):0]    cf_count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CF_W  = $clog2(MAX_CF) + 1;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [DEPTH-1:0]   cf_q;
  logic [DEPTH-1:0]   cf_d;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [CF_W-1:0]    cf_count;

  logic pop_req;
  logic has_room;
  logic cf_room;
  logic push;
  logic pop;

  assign issue_valid_o = (count_q != '0);
  assign issue_entry_o = mem_q[rd_ptr_q];
  assign issue_is_cf_o = cf_q[rd_ptr_q];
  assign count_o       = count_q;
  assign cf_count_o    = cf_count;

  // A same-cycle pop frees both a slot and, if the head is CF, a CF credit.
  always_comb begin
    pop_req         = issue_ack_i & issue_valid_o;
    has_room        = (count_q < CNT_W'(DEPTH)) | pop_req;
    cf_room         = !decoded_is_cf_i | (cf_count < CF_W'(MAX_CF)) | (pop_req & issue_is_cf_o);
    decoded_ready_o = !rst_i & decoded_valid_i & !flush_i & has_room & cf_room;
    push            = decoded_ready_o;
    pop             = pop_req & !flush_i;
  end

  always_comb begin
    mem_d    = mem_q;
    cf_d     = cf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = decoded_i;
        cf_d[wr_ptr_q]  = decoded_is_cf_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      cf_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      cf_q     <= cf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  id_issue_ctrl_counter #(
    .WIDTH (CF_W)
  ) u_cf_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (flush_i),
    .inc_i   (push & decoded_is_cf_i),
    .dec_i   (pop & issue_is_cf_o),
    .count_o (cf_count)
  );

endmodule
`default_nettype wire
